// File: rtl/wreal_edge_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wreal_edge_detector                                             |
// | Purpose  : Samples an analog input every clk rising edge, classifies it    |
// |            against a hysteresis window (HI / MID / LO), debounces the      |
// |            classification and reports confirmed edges as single-cycle     |
// |            1.0/0.0 pulses, plus saturating rise/fall/glitch counters.      |
// | Ports    : clk          - sampling clock (rising edge)                     |
// |            reset        - asynchronous, active-low reset                   |
// |            enable       - sampling enable                                  |
// |            vin          - analog input (real)                              |
// |            rising_edge  - 1.0 for one cycle on a confirmed low->high       |
// |            falling_edge - 1.0 for one cycle on a confirmed high->low       |
// |            level        - debounced logic level                            |
// |            rise_count   - confirmed rising edges (saturating)              |
// |            fall_count   - confirmed falling edges (saturating)             |
// |            glitch_count - aborted pending edges (saturating)               |
// | Config   : `EDGE_DET_DEBOUNCE_EN defined   -> DEBOUNCE-sample filter with   |
// |                                              pending states               |
// |            `EDGE_DET_DEBOUNCE_EN undefined -> one-sample transitions,      |
// |                                              glitch_count tied to 0        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wreal_edge_detector #(
  parameter real         VTH_HI   = 0.6,
  parameter real         VTH_LO   = 0.4,
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  real              vin,
  output real              rising_edge,
  output real              falling_edge,
  output logic             level,
  output logic [CNT_W-1:0] rise_count,
  output logic [CNT_W-1:0] fall_count,
  output logic [CNT_W-1:0] glitch_count
);

  // Reject configurations the comparator/filter cannot honour.
  generate
    if ((DEBOUNCE < 1) || (DEBOUNCE > 255)) begin : g_bad_debounce
      $error("wreal_edge_detector: DEBOUNCE must be within 1..255");
    end
    if (VTH_LO >= VTH_HI) begin : g_bad_thresholds
      $error("wreal_edge_detector: VTH_LO must be below VTH_HI");
    end
  endgenerate

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_LOW       = 3'd1,
    ST_HIGH      = 3'd2
`ifdef EDGE_DET_DEBOUNCE_EN
    ,
    ST_RISE_PEND = 3'd3,
    ST_FALL_PEND = 3'd4
`endif
  } state_t;

  // Sample classification; anything strictly between the thresholds is MID.
  logic w_hi;
  logic w_lo;
  assign w_hi = (vin >= VTH_HI);
  assign w_lo = (vin <= VTH_LO);

  state_t           r_state;
  logic             r_rise;
  logic             r_fall;
  logic             r_level;
  logic [CNT_W-1:0] r_rise_count;
  logic [CNT_W-1:0] r_fall_count;

`ifdef EDGE_DET_DEBOUNCE_EN
  localparam logic [7:0] c_DEBOUNCE = DEBOUNCE[7:0];
  logic [7:0]       r_count;
  logic [CNT_W-1:0] r_glitch_count;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_INIT;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_level      <= 1'b0;
      r_rise_count <= '0;
      r_fall_count <= '0;
`ifdef EDGE_DET_DEBOUNCE_EN
      r_count        <= '0;
      r_glitch_count <= '0;
`endif
    end else begin
      // Pulses are one cycle wide unless re-asserted below.
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!enable) begin
`ifdef EDGE_DET_DEBOUNCE_EN
        // A pending edge is dropped silently: disabling is not a glitch.
        r_count <= '0;
        if (r_state == ST_RISE_PEND) r_state <= ST_LOW;
        if (r_state == ST_FALL_PEND) r_state <= ST_HIGH;
`endif
      end else begin
        unique case (r_state)
          ST_INIT: begin
            r_state <= w_hi ? ST_HIGH : ST_LOW;
            r_level <= w_hi;
          end
          ST_LOW: begin
            if (w_hi) begin
`ifdef EDGE_DET_DEBOUNCE_EN
              if (c_DEBOUNCE == 8'd1) begin
                r_state <= ST_HIGH;
                r_level <= 1'b1;
                r_rise  <= 1'b1;
                if (r_rise_count != c_CNT_MAX) r_rise_count <= r_rise_count + c_CNT_ONE;
              end else begin
                r_state <= ST_RISE_PEND;
                r_count <= 8'd1;
              end
`else
              r_state <= ST_HIGH;
              r_level <= 1'b1;
              r_rise  <= 1'b1;
              if (r_rise_count != c_CNT_MAX) r_rise_count <= r_rise_count + c_CNT_ONE;
`endif
            end
          end
          ST_HIGH: begin
            if (w_lo) begin
`ifdef EDGE_DET_DEBOUNCE_EN
              if (c_DEBOUNCE == 8'd1) begin
                r_state <= ST_LOW;
                r_level <= 1'b0;
                r_fall  <= 1'b1;
                if (r_fall_count != c_CNT_MAX) r_fall_count <= r_fall_count + c_CNT_ONE;
              end else begin
                r_state <= ST_FALL_PEND;
                r_count <= 8'd1;
              end
`else
              r_state <= ST_LOW;
              r_level <= 1'b0;
              r_fall  <= 1'b1;
              if (r_fall_count != c_CNT_MAX) r_fall_count <= r_fall_count + c_CNT_ONE;
`endif
            end
          end
`ifdef EDGE_DET_DEBOUNCE_EN
          ST_RISE_PEND: begin
            if (w_hi) begin
              if ((r_count + 8'd1) == c_DEBOUNCE) begin
                r_state <= ST_HIGH;
                r_level <= 1'b1;
                r_rise  <= 1'b1;
                r_count <= '0;
                if (r_rise_count != c_CNT_MAX) r_rise_count <= r_rise_count + c_CNT_ONE;
              end else begin
                r_count <= r_count + 8'd1;
              end
            end else begin
              r_state <= ST_LOW;
              r_count <= '0;
              if (r_glitch_count != c_CNT_MAX) r_glitch_count <= r_glitch_count + c_CNT_ONE;
            end
          end
          ST_FALL_PEND: begin
            if (w_lo) begin
              if ((r_count + 8'd1) == c_DEBOUNCE) begin
                r_state <= ST_LOW;
                r_level <= 1'b0;
                r_fall  <= 1'b1;
                r_count <= '0;
                if (r_fall_count != c_CNT_MAX) r_fall_count <= r_fall_count + c_CNT_ONE;
              end else begin
                r_count <= r_count + 8'd1;
              end
            end else begin
              r_state <= ST_HIGH;
              r_count <= '0;
              if (r_glitch_count != c_CNT_MAX) r_glitch_count <= r_glitch_count + c_CNT_ONE;
            end
          end
`endif
          default: r_state <= ST_INIT;
        endcase
      end
    end
  end

  // Pulse flops are single-bit; the analog encoding is applied at the port.
  assign rising_edge  = r_rise ? 1.0 : 0.0;
  assign falling_edge = r_fall ? 1.0 : 0.0;
  assign level        = r_level;
  assign rise_count   = r_rise_count;
  assign fall_count   = r_fall_count;
`ifdef EDGE_DET_DEBOUNCE_EN
  assign glitch_count = r_glitch_count;
`else
  assign glitch_count = '0;
`endif

endmodule
`default_nettype wire
